// File: rtl/mpreduce_if.sv
// Handshake and operand/result bundle between the multi-precision adder and
// its final conditional-subtraction stage.
interface mpreduce_if #(
    parameter int LIMB_W = 257,
    parameter int NLIMBS = 4
);
    localparam int TW = LIMB_W * NLIMBS;

    logic          start;
    logic [TW-1:0] in_t;
    logic [TW-2:0] in_m;
    logic [TW-2:0] result;
    logic          sub_taken;
    logic          ovf;
    logic          busy;
    logic          done;

    // Requester side: issues operands, observes the reduced value
    modport master (
        output start, in_t, in_m,
        input  result, sub_taken, ovf, busy, done
    );

    // Reduction stage side
    modport slave (
        input  start, in_t, in_m,
        output result, sub_taken, ovf, busy, done
    );
endinterface

// File: rtl/mpreduce.sv
// Final conditional subtraction after the multi-precision adder: computes
// T - M one limb per cycle (LSB limb first, borrow chained) and returns T when
// the chain ends in a borrow (T < M), otherwise T - M, truncated to TW-1 bits.
module mpreduce #(
    parameter int LIMB_W = 257,
    parameter int NLIMBS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    mpreduce_if.slave    bus
);
    localparam int TW = LIMB_W * NLIMBS;
    localparam int CW = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        SEL  = 2'd2
    } state_t;

    state_t          stateQ;
    state_t          stateD;

    logic [TW-1:0]   tReg;
    logic [TW-1:0]   mReg;
    logic [TW-1:0]   diffReg;
    logic            borrowQ;
    logic [CW-1:0]   cntQ;

    logic [TW-2:0]   resultQ;
    logic            subTakenQ;
    logic            ovfQ;
    logic            doneQ;

    logic            load;
    logic            subEn;
    logic            selEn;
    logic            busyC;
    logic            lastLimb;

    logic [LIMB_W-1:0] limbT;
    logic [LIMB_W-1:0] limbM;
    logic [LIMB_W:0]   limbDiff;
    logic [TW-1:0]     selVal;

    // One limb of the borrow chain; the extra top bit is the borrow out
    function automatic logic [LIMB_W:0] limbSub(
        input logic [LIMB_W-1:0] a,
        input logic [LIMB_W-1:0] b,
        input logic              bin
    );
        logic [LIMB_W:0] bx;
        bx = {1'b0, b} + {{LIMB_W{1'b0}}, bin};
        return {1'b0, a} - bx;
    endfunction

    assign lastLimb = (cntQ == CW'(NLIMBS - 1));
    assign limbT    = tReg[int'(cntQ) * LIMB_W +: LIMB_W];
    assign limbM    = mReg[int'(cntQ) * LIMB_W +: LIMB_W];
    assign limbDiff = limbSub(limbT, limbM, borrowQ);

    // A final borrow means T < M, so the unmodified T is kept
    assign selVal   = borrowQ ? tReg : diffReg;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state: start only counts in IDLE; SUB walks all limbs then SEL
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (bus.start) stateD = SUB;
            SUB:     if (lastLimb)  stateD = SEL;
            SEL:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Control decode from the current state
    always_comb begin
        load  = 1'b0;
        subEn = 1'b0;
        selEn = 1'b0;
        busyC = 1'b0;
        case (stateQ)
            IDLE: load  = bus.start;
            SUB: begin
                subEn = 1'b1;
                busyC = 1'b1;
            end
            SEL: begin
                selEn = 1'b1;
                busyC = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture and limb-serial subtraction; diff fills from the top
    // so the first (least significant) limb ends up at the LSB
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tReg    <= '0;
            mReg    <= '0;
            diffReg <= '0;
            borrowQ <= 1'b0;
            cntQ    <= '0;
        end else if (load) begin
            tReg    <= bus.in_t;
            mReg    <= {1'b0, bus.in_m};
            diffReg <= '0;
            borrowQ <= 1'b0;
            cntQ    <= '0;
        end else if (subEn) begin
            diffReg <= {limbDiff[LIMB_W-1:0], diffReg[TW-1:LIMB_W]};
            borrowQ <= limbDiff[LIMB_W];
            cntQ    <= cntQ + 1'b1;
        end
    end

    // Result registers: updated only on the selection edge, held otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resultQ   <= '0;
            subTakenQ <= 1'b0;
            ovfQ      <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            doneQ <= selEn;
            if (selEn) begin
                resultQ   <= selVal[TW-2:0];
                subTakenQ <= ~borrowQ;
                ovfQ      <= selVal[TW-1];
            end
        end
    end

    assign bus.result    = resultQ;
    assign bus.sub_taken = subTakenQ;
    assign bus.ovf       = ovfQ;
    assign bus.busy      = busyC;
    assign bus.done      = doneQ;
endmodule

// File: tb/tb_mpreduce.sv
// Directed bench for mpreduce: small and wide operands, borrow chaining,
// overflow flag, handshake corner cases and asynchronous reset.
module tb_mpreduce;
    localparam int TW = 1028;

    logic clk;
    logic resetn;
    int   nCmp;
    int   nErr;

    mpreduce_if #(.LIMB_W(257), .NLIMBS(4)) bus ();

    mpreduce #(.LIMB_W(257), .NLIMBS(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed hi=%h lo=%h required hi=%h lo=%h",
                   tag, obs[TW-1:900], obs[127:0], exp[TW-1:900], exp[127:0]);
        end
    endtask

    // Issue one request, wait (bounded) for done; returns edges from accept to done
    task automatic runOp(input logic [TW-1:0] t, input logic [TW-2:0] m,
                         output int lat, output int busyCnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_t  = t;
        bus.in_m  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_t  = ~t;
        bus.in_m  = ~m;
        lat = 0;
        busyCnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busyCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chkOut(input string tag, input int lat, input logic [TW-1:0] expRes,
                          input logic expSub, input logic expOvf);
        chk({tag, ".lat"}, TW'(lat), TW'(5));
        chk({tag, ".result"}, {1'b0, bus.result}, expRes);
        chk({tag, ".sub"}, TW'(bus.sub_taken), TW'(expSub));
        chk({tag, ".ovf"}, TW'(bus.ovf), TW'(expOvf));
    endtask

    initial begin
        logic [TW-1:0] t;
        logic [TW-1:0] m;
        logic [TW-1:0] e;
        int lat;
        int bc;
        int edges;
        int doneCnt;

        nCmp = 0;
        nErr = 0;
        bus.start = 1'b0;
        bus.in_t  = '0;
        bus.in_m  = '0;
        resetn    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.result", {1'b0, bus.result}, '0);
        chk("rst.sub", TW'(bus.sub_taken), '0);
        chk("rst.ovf", TW'(bus.ovf), '0);
        chk("rst.busy", TW'(bus.busy), '0);
        chk("rst.done", TW'(bus.done), '0);
        @(negedge clk);
        resetn = 1'b1;

        // 5 - 7: no subtract
        runOp(TW'(5), (TW-1)'(7), lat, bc);
        chkOut("small_nosub", lat, TW'(5), 1'b0, 1'b0);
        chk("small_nosub.busycyc", TW'(bc), TW'(5));
        chk("small_nosub.busy_at_done", TW'(bus.busy), '0);
        @(posedge clk);
        #1;
        chk("small_nosub.done_pulse", TW'(bus.done), '0);
        chk("small_nosub.hold", {1'b0, bus.result}, TW'(5));

        // 10 - 7 = 3
        runOp(TW'(10), (TW-1)'(7), lat, bc);
        chkOut("small_sub", lat, TW'(3), 1'b1, 1'b0);

        // T == M
        t = (TW'(1) << 1026) + TW'(3);
        runOp(t, t[TW-2:0], lat, bc);
        chkOut("equal", lat, '0, 1'b1, 1'b0);

        // 2^771 - 1: borrow ripples through limbs 0..2
        t = TW'(1) << 771;
        e = t - TW'(1);
        runOp(t, (TW-1)'(1), lat, bc);
        chkOut("borrow771", lat, e, 1'b1, 1'b0);

        // 2^1027 - (2^1026 + 1) = 2^1026 - 1
        t = TW'(1) << 1027;
        m = (TW'(1) << 1026) + TW'(1);
        e = (TW'(1) << 1026) - TW'(1);
        runOp(t, m[TW-2:0], lat, bc);
        chkOut("carrybit", lat, e, 1'b1, 1'b0);

        // (2^1027 + 5) - 1 keeps the carry bit: truncated to 4, ovf set
        t = (TW'(1) << 1027) + TW'(5);
        runOp(t, (TW-1)'(1), lat, bc);
        chkOut("ovf", lat, TW'(4), 1'b1, 1'b1);

        // Start pulsed during SUB is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_t  = TW'(10);
        bus.in_m  = (TW-1)'(7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.in_t  = TW'(100);
        bus.in_m  = (TW-1)'(1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 2;
        doneCnt = 0;
        lat = 0;
        while (edges < 14) begin
            if (bus.done === 1'b1) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    lat = edges;
                    chk("ignore.result", {1'b0, bus.result}, TW'(3));
                end
            end
            @(posedge clk);
            #1;
            edges++;
        end
        chk("ignore.lat", TW'(lat), TW'(5));
        chk("ignore.donecnt", TW'(doneCnt), TW'(1));
        chk("ignore.hold", {1'b0, bus.result}, TW'(3));

        // Start in the done cycle is accepted; second done 6 cycles later
        runOp(TW'(10), (TW-1)'(7), lat, bc);
        chkOut("b2b_first", lat, TW'(3), 1'b1, 1'b0);
        bus.start = 1'b1;
        bus.in_t  = TW'(20);
        bus.in_m  = (TW-1)'(7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 1;
        while (bus.done !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("b2b.spacing", TW'(edges), TW'(6));
        chk("b2b.result", {1'b0, bus.result}, TW'(13));

        // Async reset with counter at 2
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_t  = TW'(10);
        bus.in_m  = (TW-1)'(7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.result", {1'b0, bus.result}, '0);
        chk("arst.sub", TW'(bus.sub_taken), '0);
        chk("arst.busy", TW'(bus.busy), '0);
        chk("arst.done", TW'(bus.done), '0);
        @(negedge clk);
        resetn = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) doneCnt++;
        end
        chk("arst.nodone", TW'(doneCnt), '0);
        runOp(TW'(10), (TW-1)'(7), lat, bc);
        chkOut("after_rst", lat, TW'(3), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
